// File: rtl/muldiv_sequencer.sv
// Control FSM sequencing a multi-cycle multiply/divide core for the execute stage,
// with MADD/MSUB accumulation, stall hold, bubble abort and a busy timeout.
// Optional: define MULDIV_SEQ_DIVZERO_FAST_EN to resolve divide-by-zero without the core.
module muldiv_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hold_result,
    input  logic [3:0]  muldiv_funct,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic        core_start,
    output logic        core_abort,
    output logic        core_div,
    output logic        core_signed,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [31:0] core_hi,
    input  logic [31:0] core_lo,
    input  logic        core_done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        wait_result,
    output logic        timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] F_MULT  = 4'd1;
    localparam logic [3:0] F_MULTU = 4'd2;
    localparam logic [3:0] F_DIV   = 4'd3;
    localparam logic [3:0] F_DIVU  = 4'd4;
    localparam logic [3:0] F_MADD  = 4'd5;
    localparam logic [3:0] F_MADDU = 4'd6;
    localparam logic [3:0] F_MSUB  = 4'd7;
    localparam logic [3:0] F_MSUBU = 4'd8;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    function automatic logic funct_valid(input logic [3:0] f);
        return (f >= F_MULT) && (f <= F_MSUBU);
    endfunction

    function automatic logic funct_is_div(input logic [3:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic funct_is_signed(input logic [3:0] f);
        return (f == F_MULT) || (f == F_DIV) || (f == F_MADD) || (f == F_MSUB);
    endfunction

    function automatic logic funct_is_acc(input logic [3:0] f);
        return (f == F_MADD) || (f == F_MADDU) || (f == F_MSUB) || (f == F_MSUBU);
    endfunction

    function automatic logic funct_is_sub(input logic [3:0] f);
        return (f == F_MSUB) || (f == F_MSUBU);
    endfunction

    // Accumulation is plain 64-bit two's complement on the core's raw bits.
    function automatic logic [63:0] acc_result(input logic [63:0] base,
                                               input logic [63:0] prod,
                                               input logic        acc,
                                               input logic        sub);
        logic [63:0] r;
        if (!acc) begin
            r = prod;
        end else if (sub) begin
            r = base - prod;
        end else begin
            r = base + prod;
        end
        return r;
    endfunction

    logic [1:0]    state_q,       state_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic          core_start_q,  core_start_d;
    logic          core_abort_q,  core_abort_d;
    logic          core_div_q,    core_div_d;
    logic          core_signed_q, core_signed_d;
    logic          acc_q,         acc_d;
    logic          sub_q,         sub_d;
    logic [31:0]   core_a_q,      core_a_d;
    logic [31:0]   core_b_q,      core_b_d;
    logic [63:0]   base_q,        base_d;
    logic [31:0]   hi_out_q,      hi_out_d;
    logic [31:0]   lo_out_q,      lo_out_d;
    logic          timeout_q,     timeout_d;

    logic          req_s;
    logic [63:0]   res_s;

    assign req_s = funct_valid(muldiv_funct) && !clear;
    assign res_s = acc_result(base_q, {core_hi, core_lo}, acc_q, sub_q);

    // Next-state and datapath register updates for the sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_start_d  = 1'b0;
        core_abort_d  = 1'b0;
        core_div_d    = core_div_q;
        core_signed_d = core_signed_q;
        acc_d         = acc_q;
        sub_d         = sub_q;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        base_d        = base_q;
        hi_out_d      = hi_out_q;
        lo_out_d      = lo_out_q;
        timeout_d     = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    core_a_d      = rs;
                    core_b_d      = rt;
                    core_div_d    = funct_is_div(muldiv_funct);
                    core_signed_d = funct_is_signed(muldiv_funct);
                    acc_d         = funct_is_acc(muldiv_funct);
                    sub_d         = funct_is_sub(muldiv_funct);
                    base_d        = {hi_in, lo_in};
                    cnt_d         = '0;
`ifdef MULDIV_SEQ_DIVZERO_FAST_EN
                    if (funct_is_div(muldiv_funct) && (rt == 32'd0)) begin
                        state_d  = S_DONE;
                        hi_out_d = rs;
                        lo_out_d = 32'hFFFF_FFFF;
                    end else begin
                        state_d      = S_BUSY;
                        core_start_d = 1'b1;
                    end
`else
                    state_d      = S_BUSY;
                    core_start_d = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                // A bubble beats a finishing core: its result is thrown away.
                if (clear) begin
                    core_abort_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (core_done) begin
                    hi_out_d = res_s[63:32];
                    lo_out_d = res_s[31:0];
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    core_abort_d = 1'b1;
                    timeout_d    = 1'b1;
                    hi_out_d     = 32'd0;
                    lo_out_d     = 32'd0;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (hold_result) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall request: combinational so the pipeline stalls in the request cycle itself.
    always_comb begin
        wait_result = 1'b0;
        case (state_q)
            S_IDLE:  wait_result = req_s;
            S_BUSY:  wait_result = 1'b1;
            S_DONE:  wait_result = 1'b0;
            default: wait_result = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            core_start_q  <= 1'b0;
            core_abort_q  <= 1'b0;
            core_div_q    <= 1'b0;
            core_signed_q <= 1'b0;
            acc_q         <= 1'b0;
            sub_q         <= 1'b0;
            core_a_q      <= 32'd0;
            core_b_q      <= 32'd0;
            base_q        <= 64'd0;
            hi_out_q      <= 32'd0;
            lo_out_q      <= 32'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_start_q  <= core_start_d;
            core_abort_q  <= core_abort_d;
            core_div_q    <= core_div_d;
            core_signed_q <= core_signed_d;
            acc_q         <= acc_d;
            sub_q         <= sub_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            base_q        <= base_d;
            hi_out_q      <= hi_out_d;
            lo_out_q      <= lo_out_d;
            timeout_q     <= timeout_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_abort  = core_abort_q;
    assign core_div    = core_div_q;
    assign core_signed = core_signed_q;
    assign core_a      = core_a_q;
    assign core_b      = core_b_q;
    assign hi_out      = hi_out_q;
    assign lo_out      = lo_out_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences and a
// randomized run against a plain-arithmetic reference model. The bench plays the core.
module tb_muldiv_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, clear, hold_result, core_done;
    logic [3:0]  muldiv_funct;
    logic [31:0] rs, rt, hi_in, lo_in, core_hi, core_lo;
    logic        core_start, core_abort, core_div, core_signed, wait_result, timeout;
    logic [31:0] core_a, core_b, hi_out, lo_out;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sequencer #(.TIMEOUT(TO), .CW(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .hold_result(hold_result),
        .muldiv_funct(muldiv_funct), .rs(rs), .rt(rt), .hi_in(hi_in), .lo_in(lo_in),
        .core_start(core_start), .core_abort(core_abort), .core_div(core_div),
        .core_signed(core_signed), .core_a(core_a), .core_b(core_b),
        .core_hi(core_hi), .core_lo(core_lo), .core_done(core_done),
        .hi_out(hi_out), .lo_out(lo_out), .wait_result(wait_result), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  funct;
        logic [31:0] rs, rt, hi_in, lo_in, chi, clo;
        int          lat;
        int          hold;
        logic        clr;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what HI/LO must become for an operation, from the instruction semantics.
    function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] h,
                                          input logic [31:0] l, input logic [31:0] ch,
                                          input logic [31:0] cl);
        logic [63:0] base, prod;
        base = {h, l};
        prod = {ch, cl};
        if (f == 4'd5 || f == 4'd6) return base + prod;
        if (f == 4'd7 || f == 4'd8) return base - prod;
        return prod;
    endfunction

    function automatic vec_t mk(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input logic [31:0] ch,
                                input logic [31:0] cl, input int lat, input int hold,
                                input logic clr, input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.funct = f; v.rs = a; v.rt = b; v.hi_in = h; v.lo_in = l; v.chi = ch; v.clo = cl;
        v.lat = lat; v.hold = hold; v.clr = clr; v.exp_hi = eh; v.exp_lo = el;
        return v;
    endfunction

    // One full operation: request, core handshake after v.lat BUSY cycles, DONE handling.
    task automatic run_op(input vec_t v);
        int   waits;
        logic exp_div, exp_sgn;
        exp_div = (v.funct == 4'd3) || (v.funct == 4'd4);
        exp_sgn = (v.funct == 4'd1) || (v.funct == 4'd3) || (v.funct == 4'd5) || (v.funct == 4'd7);
        @(negedge clk);
        muldiv_funct = v.funct; rs = v.rs; rt = v.rt; hi_in = v.hi_in; lo_in = v.lo_in;
        clear = 1'b0; hold_result = 1'b0; core_done = 1'b0;
        #1;
        chk("req_wait", wait_result, 1);
        waits = 1;
        for (int i = 0; i <= v.lat; i++) begin
            @(negedge clk);
            muldiv_funct = 4'd0; rs = $urandom; rt = $urandom; hi_in = $urandom; lo_in = $urandom;
            core_done = (i == v.lat);
            core_hi = (i == v.lat) ? v.chi : $urandom;
            core_lo = (i == v.lat) ? v.clo : $urandom;
            #1;
            if (i == 0) begin
                chk("core_start", core_start, 1);
                chk("core_a", core_a, v.rs);
                chk("core_b", core_b, v.rt);
                chk("core_div", core_div, exp_div);
                chk("core_signed", core_signed, exp_sgn);
            end else begin
                chk("start_pulse", core_start, 0);
            end
            if (wait_result) waits++;
        end
        @(negedge clk);
        core_done = 1'b0;
        clear = v.clr;
        hold_result = (v.hold > 0) || v.clr;
        muldiv_funct = (v.hold > 0 && !v.clr) ? 4'd1 : 4'd0;
        #1;
        chk("wait_cycles", waits, v.lat + 2);
        chk("result", {hi_out, lo_out}, {v.exp_hi, v.exp_lo});
        chk("done_wait", wait_result, 0);
        chk("no_abort", core_abort, 0);
        if (!v.clr) begin
            for (int h = 1; h <= v.hold; h++) begin
                @(negedge clk);
                hold_result = (h < v.hold);
                muldiv_funct = (h < v.hold) ? 4'd1 : 4'd0;
                core_done = (h == 1);
                core_hi = $urandom; core_lo = $urandom;
                #1;
                chk("hold_result", {hi_out, lo_out}, {v.exp_hi, v.exp_lo});
                chk("hold_wait", wait_result, 0);
            end
        end
    endtask

    vec_t tbl[7];
    vec_t rv;
    logic [63:0] e;

    initial begin
        reset = 1'b1; clear = 1'b0; hold_result = 1'b0; core_done = 1'b0;
        muldiv_funct = 4'd0; rs = 32'd0; rt = 32'd0; hi_in = 32'd0; lo_in = 32'd0;
        core_hi = 32'd0; core_lo = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        chk("rst_ops", {core_a, core_b}, 64'd0);
        chk("rst_ctl", {core_start, core_abort, core_div, core_signed, timeout, wait_result}, 6'd0);
        reset = 1'b0;

        tbl[0] = mk(4'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFE, 4, 0, 1'b0, 32'd1, 32'hFFFFFFFE);
        tbl[1] = mk(4'd7, 32'd5, 32'd5, 32'd0, 32'd10, 32'd0, 32'd25, 2, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        tbl[2] = mk(4'd3, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 3, 3, 1'b0, 32'd2, 32'd14);
        tbl[3] = mk(4'd5, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 1, 0, 1'b1, 32'd2, 32'd0);
        tbl[4] = mk(4'd6, 32'd2, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd2, 0, 1, 1'b0, 32'd0, 32'd1);
        tbl[5] = mk(4'd8, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 2, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tbl[6] = mk(4'd1, 32'h1234, 32'h5678, 32'd0, 32'd0, 32'hDEADBEEF, 32'h12345678, TO - 1, 0, 1'b0, 32'hDEADBEEF, 32'h12345678);
        for (int k = 0; k < 7; k++) run_op(tbl[k]);

        // Invalid funct and clear in IDLE must not start anything.
        @(negedge clk);
        muldiv_funct = 4'd12; clear = 1'b0; hold_result = 1'b0; #1;
        chk("nop_wait", wait_result, 0);
        @(negedge clk);
        muldiv_funct = 4'd1; clear = 1'b1; #1;
        chk("nop_start", core_start, 0);
        chk("clr_idle_wait", wait_result, 0);
        @(negedge clk);
        muldiv_funct = 4'd0; clear = 1'b0; #1;
        chk("clr_idle_start", core_start, 0);

        // clear together with core_done on BUSY cycle 2.
        @(negedge clk);
        muldiv_funct = 4'd1; rs = 32'd3; rt = 32'd4; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            muldiv_funct = 4'd0;
            clear = (i == 2); core_done = (i == 2);
            core_hi = 32'hBAD0BAD0; core_lo = 32'hBAD1BAD1;
            #1;
            chk("clr_busy_wait", wait_result, 1);
        end
        @(negedge clk);
        clear = 1'b0; core_done = 1'b0; muldiv_funct = 4'd2; rs = 32'd9; rt = 32'd9; #1;
        chk("clr_abort", core_abort, 1);
        chk("clr_keep", {hi_out, lo_out}, {32'hDEADBEEF, 32'h12345678});
        chk("clr_idle_req", wait_result, 1);
        @(negedge clk);
        muldiv_funct = 4'd0; core_done = 1'b1; core_hi = 32'd0; core_lo = 32'd81; #1;
        chk("clr_abort_pulse", core_abort, 0);
        chk("clr_restart", core_start, 1);
        @(negedge clk);
        core_done = 1'b0; #1;
        chk("clr_next_res", {hi_out, lo_out}, 64'd81);

        // Core never answers: timeout after TO BUSY cycles.
        @(negedge clk);
        muldiv_funct = 4'd4; rs = 32'd50; rt = 32'd5; #1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            muldiv_funct = 4'd0; #1;
            chk("to_wait", wait_result, 1);
            chk("to_no_abort", core_abort, 0);
        end
        @(negedge clk);
        #1;
        chk("to_abort", core_abort, 1);
        chk("to_flag", timeout, 1);
        chk("to_hilo", {hi_out, lo_out}, 64'd0);
        chk("to_wait_drop", wait_result, 0);
        @(negedge clk);
        #1;
        chk("to_abort_pulse", core_abort, 0);
        chk("to_sticky", timeout, 1);

        // Divide by zero.
`ifdef MULDIV_SEQ_DIVZERO_FAST_EN
        @(negedge clk);
        muldiv_funct = 4'd4; rs = 32'd7; rt = 32'd0; #1;
        chk("dz_req_wait", wait_result, 1);
        @(negedge clk);
        muldiv_funct = 4'd0; #1;
        chk("dz_no_start", core_start, 0);
        chk("dz_wait", wait_result, 0);
        chk("dz_result", {hi_out, lo_out}, {32'd7, 32'hFFFFFFFF});
`else
        run_op(mk(4'd4, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFFFFFF, 2, 0, 1'b0, 32'd7, 32'hFFFFFFFF));
`endif

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rv.funct = 4'($urandom_range(1, 8));
            rv.rs = $urandom; rv.rt = $urandom; rv.hi_in = $urandom; rv.lo_in = $urandom;
            if (rv.rt == 32'd0) rv.rt = 32'd1;
            rv.chi = $urandom; rv.clo = $urandom;
            rv.lat = $urandom_range(0, TO - 1);
            rv.hold = $urandom_range(0, 2);
            rv.clr = 1'b0;
            e = model(rv.funct, rv.hi_in, rv.lo_in, rv.chi, rv.clo);
            rv.exp_hi = e[63:32]; rv.exp_lo = e[31:0];
            run_op(rv);
        end
        chk("rand_sticky", timeout, 1);

        // Reset in the middle of BUSY: no abort, everything back to zero.
        @(negedge clk);
        muldiv_funct = 4'd1; rs = 32'd2; rt = 32'd3; hold_result = 1'b0; clear = 1'b0; #1;
        repeat (2) begin
            @(negedge clk);
            muldiv_funct = 4'd0;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy_abort", core_abort, 0);
        chk("rst_busy_ctl", {core_start, timeout, wait_result}, 3'd0);
        chk("rst_busy_hilo", {hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        run_op(mk(4'd2, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 32'd42, 1, 0, 1'b0, 32'd0, 32'd42));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
